// File: rtl/pwm_pkg.sv
// Shared constants for the multi-channel PWM: register map offsets and ctrl bit positions.
package pwm_pkg;

   localparam int DUTY_BASE = 0;
   localparam int EN_BIT    = 0;
   localparam int INV_BIT   = 1;
   localparam int CTRL_W    = 2;

   // Period and ctrl sit directly above the duty block, so their offsets follow the channel count.
   function automatic int period_ofs(input int n_ch);
      return DUTY_BASE + n_ch;
   endfunction

   function automatic int ctrl_ofs(input int n_ch);
      return DUTY_BASE + n_ch + 1;
   endfunction

endpackage

// File: rtl/pwm_ch_cmp.sv
// One PWM channel: double-buffered duty register, comparator against the shared counter,
// and registered output with global inversion.
module pwm_ch_cmp
   import pwm_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_duty_we,
   input  logic [CNT_W-1:0] i_wdata,
   input  logic             i_load,
   input  logic             i_en,
   input  logic             i_inv,
   input  logic [CNT_W-1:0] i_cnt,
   output logic [CNT_W-1:0] o_duty_sh,
   output logic             o_pwm
);

   logic [CNT_W-1:0] duty_sh_reg;
   logic [CNT_W-1:0] duty_act_reg;
   logic             pwm_reg;

   // i_load samples the shadow before this edge's write, so a write on a wrap edge waits a period.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         duty_sh_reg  <= '0;
         duty_act_reg <= '0;
         pwm_reg      <= 1'b0;
      end else begin
         if (i_duty_we)
            duty_sh_reg <= i_wdata;
         if (i_load)
            duty_act_reg <= duty_sh_reg;
         pwm_reg <= i_en ? ((i_cnt < duty_act_reg) ^ i_inv) : 1'b0;
      end
   end

   assign o_duty_sh = duty_sh_reg;
   assign o_pwm     = pwm_reg;

endmodule

// File: rtl/pwm_multi_ch.sv
// N-channel PWM generator: CPU register file, shared period counter with glitch-free
// period-boundary reloads, and one comparator channel per output.
module pwm_multi_ch
   import pwm_pkg::*;
#(
   parameter int N_CH   = 4,
   parameter int CNT_W  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_cs,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [CNT_W-1:0]  i_wdata,
   output logic [CNT_W-1:0]  o_rdata,
   output logic [N_CH-1:0]   o_pwm,
   output logic              o_period_end
);

   localparam logic [ADDR_W-1:0] PERIOD_ADDR = ADDR_W'(period_ofs(N_CH));
   localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(ctrl_ofs(N_CH));

   logic              wr_en;
   logic              rd_en;
   logic              en;
   logic              inv;
   logic              wrap;
   logic              load;
   logic [CNT_W-1:0]  period_sh_reg;
   logic [CNT_W-1:0]  period_act_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [CNT_W-1:0]  rdata_reg;
   logic [CNT_W-1:0]  rdata_next;
   logic [CTRL_W-1:0] ctrl_reg;
   logic              period_end_reg;
   logic [N_CH-1:0]   duty_we;
   logic [N_CH-1:0]   pwm_bits;
   logic [CNT_W-1:0]  duty_sh [N_CH];

   assign wr_en = !i_cs && i_we;
   assign rd_en = !i_cs && !i_we;
   assign en    = ctrl_reg[EN_BIT];
   assign inv   = ctrl_reg[INV_BIT];
   assign wrap  = en && (cnt_reg == period_act_reg);
   // While disabled the active copies track the shadows, so enabling starts from fresh values.
   assign load  = !en || wrap;

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         assign duty_we[gi] = wr_en && (i_addr == ADDR_W'(DUTY_BASE + gi));

         pwm_ch_cmp #(
            .CNT_W (CNT_W)
         ) u_ch (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_duty_we (duty_we[gi]),
            .i_wdata   (i_wdata),
            .i_load    (load),
            .i_en      (en),
            .i_inv     (inv),
            .i_cnt     (cnt_reg),
            .o_duty_sh (duty_sh[gi]),
            .o_pwm     (pwm_bits[gi])
         );
      end
   endgenerate

   always_comb begin
      rdata_next = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (i_addr == ADDR_W'(DUTY_BASE + k))
            rdata_next = duty_sh[k];
      end
      if (i_addr == PERIOD_ADDR)
         rdata_next = period_sh_reg;
      if (i_addr == CTRL_ADDR)
         rdata_next = CNT_W'(ctrl_reg);
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         period_sh_reg  <= '0;
         period_act_reg <= '0;
         ctrl_reg       <= '0;
         cnt_reg        <= '0;
         period_end_reg <= 1'b0;
         rdata_reg      <= '0;
      end else begin
         if (wr_en && (i_addr == PERIOD_ADDR))
            period_sh_reg <= i_wdata;
         if (wr_en && (i_addr == CTRL_ADDR))
            ctrl_reg <= i_wdata[CTRL_W-1:0];
         if (load)
            period_act_reg <= period_sh_reg;
         // Counter never passes period_act, so the increment cannot overflow.
         if (load)
            cnt_reg <= '0;
         else
            cnt_reg <= cnt_reg + CNT_W'(1);
         period_end_reg <= wrap;
         if (rd_en)
            rdata_reg <= rdata_next;
      end
   end

   assign o_rdata      = rdata_reg;
   assign o_pwm        = pwm_bits;
   assign o_period_end = period_end_reg;

endmodule
